// File: rtl/mips_run_ctrl_if.sv
// Bundle between the run controller and its environment: program word
// stream, instruction-memory write port, core run control, register-file
// read port, register dump stream and status.
//   master : controller side (mips_run_ctrl)
//   slave  : environment side (loader, memory, core, dump sink)
interface mips_run_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
);
  // command
  logic              start;
  logic [ADDR_W:0]   prog_len;
  // program stream
  logic              prog_valid;
  logic [31:0]       prog_data;
  logic              prog_ready;
  // instruction-memory write port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  // core control
  logic              core_pc_rst;
  logic              core_run;
  logic              core_halted;
  logic [CNT_W-1:0]  timeout_lim;
  // register-file read port
  logic [4:0]        rf_raddr;
  logic [31:0]       rf_rdata;
  // register dump stream
  logic              dump_valid;
  logic              dump_ready;
  logic [31:0]       dump_data;
  logic [4:0]        dump_idx;
  // status
  logic              busy;
  logic              done;
  logic              timed_out;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    input  start, prog_len, prog_valid, prog_data, core_halted, timeout_lim,
           rf_rdata, dump_ready,
    output prog_ready, imem_we, imem_addr, imem_wdata, core_pc_rst, core_run,
           rf_raddr, dump_valid, dump_data, dump_idx, busy, done, timed_out,
           cycle_count
  );

  modport slave (
    output start, prog_len, prog_valid, prog_data, core_halted, timeout_lim,
           rf_rdata, dump_ready,
    input  prog_ready, imem_we, imem_addr, imem_wdata, core_pc_rst, core_run,
           rf_raddr, dump_valid, dump_data, dump_idx, busy, done, timed_out,
           cycle_count
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for a small MIPS core: loads a program into instruction
// memory, resets the PC, lets the core run until HLT or a cycle limit,
// then streams out all 32 registers.
// Ports:
//   clk1  : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mips_run_ctrl_if master (program stream, imem write, core
//           control, register-file read, dump stream, status)
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | waiting for start with a non-zero length
// LOAD       | accepting program words, writing imem
// PCRST      | one-cycle PC reset pulse to the core
// RUN        | core running, counting cycles, watching halt/timeout
// DUMP_RD    | register-file read address presented, data captured
// DUMP_OUT   | register value offered on the dump stream
// DONE       | finished; status held until the next start
module mips_run_ctrl #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input logic            clk1,
  input logic            rst_n,
  mips_run_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_PCRST    = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DUMP_RD  = 3'd4;
  localparam logic [2:0] S_DUMP_OUT = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [ADDR_W:0]  len_q, len_d;
  // one bit wider than imem_addr so the last-word compare works for any
  // legal prog_len
  logic [ADDR_W:0]  addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic [4:0]       idx_q, idx_d;
  logic [31:0]      dd_q, dd_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             start_ok;
  logic             last_word;
  logic             lim_hit;

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign start_ok  = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                     bus.start && (bus.prog_len != '0);
  assign last_word = (addr_q == len_q - 1'b1);
  assign lim_hit   = (bus.timeout_lim != '0) && (cnt_inc == bus.timeout_lim);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    idx_d   = idx_q;
    dd_d    = dd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          len_d   = bus.prog_len;
          addr_d  = '0;
          to_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.prog_valid) begin
          addr_d = addr_q + 1'b1;
          if (last_word) state_d = S_PCRST;
        end
      end
      S_PCRST: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // halt wins over a timeout on the same edge: no increment, no flag
        if (bus.core_halted) begin
          idx_d   = '0;
          state_d = S_DUMP_RD;
        end else begin
          cnt_d = cnt_inc;
          if (lim_hit) begin
            to_d    = 1'b1;
            idx_d   = '0;
            state_d = S_DUMP_RD;
          end
        end
      end
      S_DUMP_RD: begin
        dd_d    = bus.rf_rdata;
        state_d = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (bus.dump_ready) begin
          if (idx_q == 5'd31) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DUMP_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      idx_q   <= '0;
      dd_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
      dd_q    <= dd_d;
    end
  end

  // all control outputs decode from state_q, so an async reset drops them
  // in the same cycle
  assign bus.prog_ready  = (state_q == S_LOAD);
  assign bus.imem_we     = (state_q == S_LOAD) && bus.prog_valid;
  assign bus.imem_addr   = addr_q[ADDR_W-1:0];
  assign bus.imem_wdata  = (state_q == S_LOAD) ? bus.prog_data : 32'd0;
  assign bus.core_pc_rst = (state_q == S_PCRST);
  assign bus.core_run    = (state_q == S_RUN);
  assign bus.rf_raddr    = idx_q;
  assign bus.dump_valid  = (state_q == S_DUMP_OUT);
  assign bus.dump_data   = dd_q;
  assign bus.dump_idx    = idx_q;
  assign bus.busy        = (state_q == S_LOAD) || (state_q == S_PCRST) ||
                           (state_q == S_RUN) || (state_q == S_DUMP_RD) ||
                           (state_q == S_DUMP_OUT);
  assign bus.done        = (state_q == S_DONE);
  assign bus.timed_out   = to_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: instruction-memory address width.
REQ-002 SHALL have parameter CNT_W, default 16: width of the cycle counter and timeout limit.
REQ-003 SHALL have port clk1, input, 1: single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports start (in, 1) and prog_len (in, ADDR_W+1): start pulse and number of program words.
REQ-006 SHALL have ports prog_valid (in, 1), prog_data (in, 32) and prog_ready (out, 1): program word stream.
REQ-007 SHALL have ports imem_we (out, 1), imem_addr (out, ADDR_W) and imem_wdata (out, 32): instruction-memory write port.
REQ-008 SHALL have ports core_pc_rst (out, 1), core_run (out, 1) and core_halted (in, 1): core control (PC to 0, release HALTED, HLT reached).
REQ-009 SHALL have port timeout_lim, input, CNT_W: RUN cycle limit, where 0 disables the timeout.
REQ-010 SHALL have ports rf_raddr (out, 5) and rf_rdata (in, 32): register-file read port, combinational read.
REQ-011 SHALL have ports dump_valid (out, 1), dump_ready (in, 1), dump_data (out, 32) and dump_idx (out, 5): register dump stream.
REQ-012 SHALL have ports busy, done and timed_out (out, 1 each) and cycle_count (out, CNT_W): status.

Function
REQ-013 SHALL implement states IDLE, LOAD, PCRST, RUN, DUMP_RD, DUMP_OUT and DONE.
REQ-014 In IDLE or DONE, start with prog_len != 0 SHALL latch prog_len, clear the load address, done and timed_out, and go to LOAD.
REQ-015 In IDLE or DONE, start with prog_len == 0 SHALL be ignored.
REQ-016 start in any other state SHALL be ignored.
REQ-017 In LOAD, prog_ready SHALL be 1; imem_we = prog_valid; imem_addr = load address; imem_wdata = prog_data, all combinational.
REQ-018 The load address SHALL increment on each accepted word.
REQ-019 Acceptance of word prog_len-1 SHALL move to PCRST.
REQ-020 Gaps in prog_valid SHALL produce no writes.
REQ-021 PCRST SHALL last exactly 1 cycle, assert core_pc_rst, clear cycle_count and go to RUN.
REQ-022 In RUN, core_run SHALL be 1; on each edge with core_halted=1 the FSM SHALL go to DUMP_RD.
REQ-023 In RUN, on each edge with core_halted=0, cycle_count SHALL increment, saturating at all-ones.
REQ-024 In RUN, if timeout_lim != 0 and the incremented count equals timeout_lim, the FSM SHALL set timed_out and go to DUMP_RD.
REQ-025 core_halted=1 and the timeout on the same edge SHALL resolve to halt: timed_out=0 and cycle_count not incremented.
REQ-026 In DUMP_RD (1 cycle), rf_raddr SHALL equal the dump index and rf_rdata SHALL be registered into dump_data at the edge leaving DUMP_RD.
REQ-027 In DUMP_OUT, dump_valid SHALL be 1 and dump_idx equal the index; dump_data/dump_idx SHALL stay stable while dump_ready=0.
REQ-028 A DUMP_OUT handshake at index 31 SHALL go to DONE; at any other index it SHALL increment the index and go to DUMP_RD.
REQ-029 Register dump SHALL take 2 cycles minimum per register and run index 0..31 in order.
REQ-030 core_run SHALL be 0 outside RUN; core_pc_rst SHALL be 0 outside PCRST; prog_ready SHALL be 0 outside LOAD.
REQ-031 busy SHALL be 1 in LOAD, PCRST, RUN, DUMP_RD and DUMP_OUT.
REQ-032 done SHALL be 1 only in DONE; cycle_count and timed_out SHALL hold their values in DONE.

Reset
REQ-033 On rst_n low, the state SHALL be IDLE immediately, asynchronously, regardless of the current state.
REQ-034 During reset, all outputs, counters, the latched length and dump_data SHALL be 0.
REQ-035 Reset mid-RUN SHALL drop core_run within the same cycle as rst_n falls.
REQ-036 Release SHALL be synchronous to clk1; the first active edge after release SHALL see IDLE.

Verification
REQ-037 Start with prog_len=9 and 9 words streamed back-to-back (h2820000a .. hfc000000); core_halted rises after 40 RUN cycles -> imem writes addr 0..8, one core_pc_rst pulse, cycle_count=40, dumps idx 0..31 with R1=10, R2=20, R3=25, R4=30, R5=55, R6=45, done=1, timed_out=0.
REQ-038 prog_valid with random gaps, plus dump_ready low 3 cycles at idx 5 -> exactly 9 writes with no duplicates; dump_data/idx stable for the stall; no index skipped.
REQ-039 timeout_lim=20, core_halted held 0 -> timed_out=1, cycle_count=20, RUN exited after 20 cycles, full dump, done=1.
REQ-040 timeout_lim=20, core_halted rises on the 20th RUN edge -> timed_out=0, cycle_count=19.
REQ-041 rst_n pulsed low mid-RUN -> core_run=0 at once, state IDLE, cycle_count=0, busy=0.
REQ-042 start while busy, and start with prog_len=0 in IDLE -> no state change, no imem writes.
